// File: rtl/spsram_req_ctrl.sv
// spsram_req_ctrl
// Initiator-side controller for a single-port SRAM macro (A/CEN/WEN/D/Q).
// It turns a valid/ready request stream (reads and byte-masked writes) into
// SRAM cycles issued in the acceptance cycle. Read data returns through a
// small response FIFO that absorbs response-side backpressure. An optional
// post-reset zero-fill clears the whole array before any request is taken.
//
// Ports:
//   CLK, RST             clock (posedge) and asynchronous active-high reset
//   req_vld/req_rdy      request handshake
//   req_wr               1 = write, 0 = read
//   req_addr             word address
//   req_wdata, req_be    write data and active-high byte enables
//   rsp_vld/rsp_rdy      read response handshake
//   rsp_rdata            read data, in read-acceptance order
//   init_done            high once the zero-fill has finished
//   sram_a/cen/wen/d     SRAM address, chip enable (low), byte write enables (low), data
//   sram_q               SRAM read data, valid the cycle after a CEN-low read
module spsram_req_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128,
  parameter int BYTE_NUM   = 16,
  parameter int RSP_DEPTH  = 2,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BYTE_NUM-1:0]   req_be,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic [BYTE_NUM-1:0]   sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = CNT_W + 1;
  localparam int INIT_W = ADDR_WIDTH + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1'b1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [SUM_W-1:0]  DEPTH_SUM = SUM_W'(RSP_DEPTH);

  logic [0:0]            state_r;
  logic [INIT_W-1:0]     init_cnt_r;
  logic [INIT_W-1:0]     init_cnt_nxt_s;
  logic                  init_done_r;
  logic                  rd_inflight_r;
  logic [DATA_WIDTH-1:0] fifo_mem_r [0:RSP_DEPTH-1];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      fifo_cnt_r;
  logic [SUM_W-1:0]      credit_sum_s;
  logic                  credit_s;
  logic                  accept_s;
  logic                  fifo_empty_s;
  logic                  pop_s;
  logic                  pop_fifo_s;
  logic                  push_s;

  assign init_done = init_done_r;

  // Credit check: an outstanding read always has a FIFO slot reserved for it.
  always_comb begin
    credit_sum_s = {1'b0, fifo_cnt_r} + {{CNT_W{1'b0}}, rd_inflight_r};
    if (RST) begin
      credit_s = 1'b0;
    end else begin
      credit_s = (state_r == ST_RUN) && (credit_sum_s < DEPTH_SUM);
    end
    req_rdy  = credit_s;
    accept_s = req_vld && credit_s;
  end

  // SRAM drive: zero-fill pattern in INIT, request pass-through in RUN.
  // Reset forces the idle drive so the macro sees no access while RST is high.
  always_comb begin
    sram_cen = 1'b1;
    sram_wen = {BYTE_NUM{1'b1}};
    sram_a   = {ADDR_WIDTH{1'b0}};
    sram_d   = {DATA_WIDTH{1'b0}};
    if (RST) begin
      sram_cen = 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          sram_cen = 1'b0;
          sram_wen = {BYTE_NUM{1'b0}};
          sram_a   = init_cnt_r[ADDR_WIDTH-1:0];
          sram_d   = {DATA_WIDTH{1'b0}};
        end
        ST_RUN: begin
          sram_a = req_addr;
          sram_d = req_wdata;
          if (accept_s) begin
            sram_cen = 1'b0;
            // A write with req_be == 0 still strobes CEN but changes nothing.
            sram_wen = req_wr ? ~req_be : {BYTE_NUM{1'b1}};
          end else begin
            sram_cen = 1'b1;
            sram_wen = {BYTE_NUM{1'b1}};
          end
        end
        default: begin
          sram_cen = 1'b1;
          sram_wen = {BYTE_NUM{1'b1}};
        end
      endcase
    end
  end

  // Response side: FIFO head when non-empty, else Q is bypassed straight out
  // so a read into an empty FIFO answers one cycle after acceptance.
  always_comb begin
    fifo_empty_s = (fifo_cnt_r == {CNT_W{1'b0}});
    rsp_vld      = !fifo_empty_s || rd_inflight_r;
    if (!fifo_empty_s) begin
      rsp_rdata = fifo_mem_r[rd_ptr_r];
    end else if (rd_inflight_r) begin
      rsp_rdata = sram_q;
    end else begin
      rsp_rdata = {DATA_WIDTH{1'b0}};
    end
    pop_s      = rsp_vld && rsp_rdy;
    pop_fifo_s = pop_s && !fifo_empty_s;
    // A bypassed word consumed in its own cycle never enters the FIFO.
    push_s     = rd_inflight_r && !(fifo_empty_s && pop_s);
  end

  // Next zero-fill address; the extra MSB flags the terminal count.
  always_comb begin
    init_cnt_nxt_s = init_cnt_r + INIT_ONE;
  end

  // Control state: INIT/RUN, zero-fill counter, init_done flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      init_cnt_r  <= {INIT_W{1'b0}};
      init_done_r <= (INIT_EN != 0) ? 1'b0 : 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_nxt_s;
          if (init_cnt_nxt_s[ADDR_WIDTH]) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  // Read tracking and response FIFO storage/pointers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_inflight_r <= 1'b0;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      fifo_cnt_r    <= {CNT_W{1'b0}};
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      rd_inflight_r <= accept_s && !req_wr;
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= sram_q;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_fifo_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_fifo_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

endmodule
